rs_param: RTL

RS_PARAM -- requirements
Module: rs_param

---
 rtl/rs_param_if.sv | 56 +++++
 rtl/rs_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_param_if.sv
// rs_param_if -- bundle of the reservation station's dispatch, result
// broadcast (CDB) and ALU issue signals.
//   master : the surrounding pipeline (drives in_*, observes out_*)
//   slave  : the reservation station (observes in_*, drives out_*)
// Parameters must match those of the rs_param instance it connects to.
interface rs_param_if #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int ROB_TAG_W = 4,
  parameter int OP_W      = 6,
  parameter int NUM_CDB   = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Dispatch
  logic                         in_disp_valid;
  logic                         out_disp_ready;
  logic [OP_W-1:0]              in_disp_op;
  logic [DATA_W-1:0]            in_disp_pc;
  logic [DATA_W-1:0]            in_disp_imm;
  logic [ROB_TAG_W-1:0]         in_disp_reorder;
  logic [ROB_TAG_W-1:0]         in_disp_rs1_tag;
  logic [ROB_TAG_W-1:0]         in_disp_rs2_tag;
  logic [DATA_W-1:0]            in_disp_rs1_val;
  logic [DATA_W-1:0]            in_disp_rs2_val;
  // Result broadcast, port k in slice k
  logic [NUM_CDB-1:0]           in_cdb_valid;
  logic [NUM_CDB*ROB_TAG_W-1:0] in_cdb_tag;
  logic [NUM_CDB*DATA_W-1:0]    in_cdb_val;
  // Issue
  logic                         out_alu_valid;
  logic                         in_alu_ready;
  logic [OP_W-1:0]              out_alu_op;
  logic [DATA_W-1:0]            out_alu_pc;
  logic [DATA_W-1:0]            out_alu_imm;
  logic [DATA_W-1:0]            out_alu_rs1;
  logic [DATA_W-1:0]            out_alu_rs2;
  logic [ROB_TAG_W-1:0]         out_alu_reorder;
  logic [CNT_W-1:0]             out_count;

  modport master (
    output in_disp_valid, in_disp_op, in_disp_pc, in_disp_imm, in_disp_reorder,
           in_disp_rs1_tag, in_disp_rs2_tag, in_disp_rs1_val, in_disp_rs2_val,
           in_cdb_valid, in_cdb_tag, in_cdb_val, in_alu_ready,
    input  out_disp_ready, out_alu_valid, out_alu_op, out_alu_pc, out_alu_imm,
           out_alu_rs1, out_alu_rs2, out_alu_reorder, out_count
  );

  modport slave (
    input  in_disp_valid, in_disp_op, in_disp_pc, in_disp_imm, in_disp_reorder,
           in_disp_rs1_tag, in_disp_rs2_tag, in_disp_rs1_val, in_disp_rs2_val,
           in_cdb_valid, in_cdb_tag, in_cdb_val, in_alu_ready,
    output out_disp_ready, out_alu_valid, out_alu_op, out_alu_pc, out_alu_imm,
           out_alu_rs1, out_alu_rs2, out_alu_reorder, out_count
  );
endinterface

// File: rtl/rs_param.sv
// rs_param -- parameterised reservation station feeding one ALU.
// Holds up to DEPTH dispatched instructions, captures operands from the
// result broadcast ports (with same-cycle bypass at allocation), and issues
// one ready instruction per cycle into a registered, backpressured output.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   rdy      : global enable; low freezes every register
//   in_flush : misbranch flush, frees all entries and drops the issue slot
//   bus      : rs_param_if.slave (dispatch, CDB, issue, out_count)
// Build option: define RS_AGE_ORDER_EN to issue the oldest ready entry
// instead of the lowest-index ready entry.
module rs_param #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int ROB_TAG_W = 4,
  parameter int OP_W      = 6,
  parameter int NUM_CDB   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       in_flush,
  rs_param_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [OP_W-1:0]  OP_NOP    = '0;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [DATA_W-1:0]    pc;
    logic [DATA_W-1:0]    imm;
    logic [ROB_TAG_W-1:0] reorder;
    logic [ROB_TAG_W-1:0] q1;   // 0 once v1 holds the operand
    logic [ROB_TAG_W-1:0] q2;
    logic [DATA_W-1:0]    v1;
    logic [DATA_W-1:0]    v2;
  } entry_t;

  entry_t               ent      [DEPTH];
  entry_t               ent_wake [DEPTH];
  entry_t               new_ent;
  logic [DEPTH-1:0]     busy, busy_nxt, ready, issue_mask, alloc_mask;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [IDX_W-1:0]     free_idx, sel_idx;
  logic                 any_ready, disp_ready, disp_fire, issue_ok, issue_fire;

  logic                 alu_valid;
  logic [OP_W-1:0]      alu_op;
  logic [DATA_W-1:0]    alu_pc, alu_imm, alu_rs1, alu_rs2;
  logic [ROB_TAG_W-1:0] alu_reorder;

  logic [NUM_CDB-1:0]   cdb_valid;
  logic [ROB_TAG_W-1:0] cdb_tag [NUM_CDB];
  logic [DATA_W-1:0]    cdb_val [NUM_CDB];

  always_comb begin
    cdb_valid = bus.in_cdb_valid;
    for (int k = 0; k < NUM_CDB; k++) begin
      cdb_tag[k] = bus.in_cdb_tag[k*ROB_TAG_W +: ROB_TAG_W];
      cdb_val[k] = bus.in_cdb_val[k*DATA_W +: DATA_W];
    end
  end

  // Returns {hit, value}. Scanning from the top port down lets the lowest
  // matching port win; tag 0 never matches since it means "no producer".
  function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_TAG_W-1:0] tag);
    logic [DATA_W:0] res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--)
      if (cdb_valid[k] && cdb_tag[k] != '0 && cdb_tag[k] == tag)
        res = {1'b1, cdb_val[k]};
    return res;
  endfunction

  // Incoming entry with same-cycle bypass applied.
  // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
  always_comb begin
    logic [DATA_W:0] h1, h2;
    h1 = cdb_lookup(bus.in_disp_rs1_tag);
    h2 = cdb_lookup(bus.in_disp_rs2_tag);
    new_ent.op      = bus.in_disp_op;
    new_ent.pc      = bus.in_disp_pc;
    new_ent.imm     = bus.in_disp_imm;
    new_ent.reorder = bus.in_disp_reorder;
    new_ent.q1      = bus.in_disp_rs1_tag;
    new_ent.v1      = bus.in_disp_rs1_val;
    new_ent.q2      = bus.in_disp_rs2_tag;
    new_ent.v2      = bus.in_disp_rs2_val;
    if (h1[DATA_W]) begin
      new_ent.q1 = '0;
      new_ent.v1 = h1[DATA_W-1:0];
    end
    if (h2[DATA_W]) begin
      new_ent.q2 = '0;
      new_ent.v2 = h2[DATA_W-1:0];
    end
  end

  // Stored entries with this cycle's broadcasts applied.
  always_comb begin
    logic [DATA_W:0] w1, w2;
    w1 = '0;
    w2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_wake[i] = ent[i];
      w1 = cdb_lookup(ent[i].q1);
      w2 = cdb_lookup(ent[i].q2);
      if (w1[DATA_W]) begin
        ent_wake[i].q1 = '0;
        ent_wake[i].v1 = w1[DATA_W-1:0];
      end
      if (w2[DATA_W]) begin
        ent_wake[i].q2 = '0;
        ent_wake[i].v2 = w2[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    ready    = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      ready[i] = busy[i] && ent[i].q1 == '0 && ent[i].q2 == '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) free_idx = IDX_W'(i);
  end

`ifdef RS_AGE_ORDER_EN
  // older[i][j] set: entry j was dispatched before entry i.
  logic [DEPTH-1:0] older     [DEPTH];
  logic [DEPTH-1:0] older_nxt [DEPTH];

  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready[i] && (older[i] & ready) == '0) sel_idx = IDX_W'(i);
  end

  always_comb begin
    older_nxt = older;
    for (int j = 0; j < DEPTH; j++)
      older_nxt[j] = older[j] & ~issue_mask & ~alloc_mask;
    if (disp_fire) older_nxt[free_idx] = busy & ~issue_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (rdy) begin
      if (in_flush) begin
        for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else begin
        older <= older_nxt;
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (ready[i]) sel_idx = IDX_W'(i);
  end
`endif

  always_comb begin
    any_ready  = |ready;
    disp_ready = count < DEPTH_CNT;
    disp_fire  = bus.in_disp_valid && disp_ready;
    issue_ok   = !alu_valid || bus.in_alu_ready;
    issue_fire = issue_ok && any_ready;
    issue_mask = '0;
    alloc_mask = '0;
    if (issue_fire) issue_mask[sel_idx] = 1'b1;
    if (disp_fire)  alloc_mask[free_idx] = 1'b1;
    busy_nxt  = (busy & ~issue_mask) | alloc_mask;
    count_nxt = count + CNT_W'(disp_fire) - CNT_W'(issue_fire);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      count       <= '0;
      alu_valid   <= 1'b0;
      alu_op      <= OP_NOP;
      alu_pc      <= '0;
      alu_imm     <= '0;
      alu_rs1     <= '0;
      alu_rs2     <= '0;
      alu_reorder <= '0;
    end else if (rdy) begin
      if (in_flush) begin
        busy      <= '0;
        count     <= '0;
        alu_valid <= 1'b0;
      end else begin
        busy  <= busy_nxt;
        count <= count_nxt;
        if (issue_ok) begin
          alu_valid <= any_ready;
          if (any_ready) begin
            alu_op      <= ent[sel_idx].op;
            alu_pc      <= ent[sel_idx].pc;
            alu_imm     <= ent[sel_idx].imm;
            alu_rs1     <= ent[sel_idx].v1;
            alu_rs2     <= ent[sel_idx].v2;
            alu_reorder <= ent[sel_idx].reorder;
          end
        end
      end
    end
  end

  // NOTE: entry payloads are not reset; a cleared busy bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (rdy && !in_flush) begin
      for (int i = 0; i < DEPTH; i++)
        if (busy[i]) ent[i] <= ent_wake[i];
      if (disp_fire) ent[free_idx] <= new_ent;
    end
  end

  assign bus.out_disp_ready  = disp_ready;
  assign bus.out_alu_valid   = alu_valid;
  assign bus.out_alu_op      = alu_op;
  assign bus.out_alu_pc      = alu_pc;
  assign bus.out_alu_imm     = alu_imm;
  assign bus.out_alu_rs1     = alu_rs1;
  assign bus.out_alu_rs2     = alu_rs2;
  assign bus.out_alu_reorder = alu_reorder;
  assign bus.out_count       = count;
endmodule
